// File: rtl/srio_pkg.sv
// Shared SRIO definitions: packet type codes, header field positions,
// doorbell info codes and the target responder state encoding.
package srio_pkg;

    localparam logic [3:0] FTYPE_DB  = 4'hA;
    localparam logic [3:0] FTYPE_NWR = 4'h5;
    localparam logic [3:0] TTYPE_NWR = 4'h4;

    localparam int TID_MSB   = 63;
    localparam int TID_LSB   = 56;
    localparam int FTYPE_MSB = 55;
    localparam int FTYPE_LSB = 52;
    localparam int TTYPE_MSB = 51;
    localparam int TTYPE_LSB = 48;
    localparam int PRIO_MSB  = 46;
    localparam int PRIO_LSB  = 45;
    localparam int SIZE_MSB  = 43;
    localparam int SIZE_LSB  = 36;
    localparam int ADDR_MSB  = 33;
    localparam int ADDR_LSB  = 0;
    localparam int INFO_MSB  = 31;
    localparam int INFO_LSB  = 16;

    localparam logic [15:0] DB_QUERY_INFO_DEF = 16'h0101;
    localparam logic [15:0] DB_READY_INFO_DEF = 16'h0100;
    localparam logic [15:0] DB_BUSY_INFO_DEF  = 16'h01FF;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DB_RESP  = 2'd1,
        NWR_DATA = 2'd2,
        DROP     = 2'd3
    } state_e;

    // Responses go out one priority level above the request, capped at 3.
    function automatic logic [1:0] prio_inc(input logic [1:0] prio);
        return (prio == 2'h3) ? 2'h3 : prio + 2'h1;
    endfunction

    function automatic logic [63:0] db_resp_hdr(input logic [7:0]  tid,
                                                input logic [1:0]  prio,
                                                input logic [15:0] info);
        return {tid, FTYPE_DB, 4'h0, 1'b0, prio_inc(prio), 1'b0, 12'h000, info, 16'h0000};
    endfunction

endpackage

// File: rtl/db_target_resp_if.sv
// Request, response and user write-port signals of the doorbell/NWRITE target.
// The slave modport is the target's view; master is the environment's view.
interface db_target_resp_if;

    logic        link_initialized;

    logic        treq_tvalid_in;
    logic        treq_tready_o;
    logic        treq_tlast_in;
    logic [63:0] treq_tdata_in;
    logic [7:0]  treq_tkeep_in;
    logic [31:0] treq_tuser_in;

    logic        tresp_tvalid_o;
    logic        tresp_tready_in;
    logic        tresp_tlast_o;
    logic [63:0] tresp_tdata_o;
    logic [7:0]  tresp_tkeep_o;
    logic [31:0] tresp_tuser_o;

    logic        user_busy_in;
    logic        user_wr_ready_in;
    logic        user_wr_en_o;
    logic [33:0] user_wr_addr_o;
    logic [63:0] user_wr_data_o;
    logic [7:0]  user_wr_keep_o;
    logic        user_wr_last_o;

    logic        nwr_done_o;
    logic        nwr_err_o;
    logic [15:0] db_rx_cnt_o;

    modport slave (
        input  link_initialized,
        input  treq_tvalid_in, treq_tlast_in, treq_tdata_in, treq_tkeep_in, treq_tuser_in,
        output treq_tready_o,
        output tresp_tvalid_o, tresp_tlast_o, tresp_tdata_o, tresp_tkeep_o, tresp_tuser_o,
        input  tresp_tready_in,
        input  user_busy_in, user_wr_ready_in,
        output user_wr_en_o, user_wr_addr_o, user_wr_data_o, user_wr_keep_o, user_wr_last_o,
        output nwr_done_o, nwr_err_o, db_rx_cnt_o
    );

    modport master (
        output link_initialized,
        output treq_tvalid_in, treq_tlast_in, treq_tdata_in, treq_tkeep_in, treq_tuser_in,
        input  treq_tready_o,
        input  tresp_tvalid_o, tresp_tlast_o, tresp_tdata_o, tresp_tkeep_o, tresp_tuser_o,
        output tresp_tready_in,
        output user_busy_in, user_wr_ready_in,
        input  user_wr_en_o, user_wr_addr_o, user_wr_data_o, user_wr_keep_o, user_wr_last_o,
        input  nwr_done_o, nwr_err_o, db_rx_cnt_o
    );

endinterface

// File: rtl/srio_hdr_decode.sv
// Combinational split of a 64-bit SRIO header beat into the fields used by
// both the target request path and the initiator's response parser.
module srio_hdr_decode
    import srio_pkg::*;
(
    input  logic [63:0] hdr,
    output logic        is_db,
    output logic        is_nwr,
    output logic [7:0]  tid,
    output logic [1:0]  prio,
    output logic [7:0]  size,
    output logic [33:0] addr,
    output logic [15:0] info
);

    logic [3:0] ftype;
    logic [3:0] ttype;
    logic       unused_hdr_bits;

    assign ftype  = hdr[FTYPE_MSB:FTYPE_LSB];
    assign ttype  = hdr[TTYPE_MSB:TTYPE_LSB];
    assign tid    = hdr[TID_MSB:TID_LSB];
    assign prio   = hdr[PRIO_MSB:PRIO_LSB];
    assign size   = hdr[SIZE_MSB:SIZE_LSB];
    assign addr   = hdr[ADDR_MSB:ADDR_LSB];
    assign info   = hdr[INFO_MSB:INFO_LSB];

    // Doorbells carry no transaction subtype; NWRITE shares ftype 5 with other writes.
    assign is_db  = (ftype == FTYPE_DB);
    assign is_nwr = (ftype == FTYPE_NWR) && (ttype == TTYPE_NWR);

    assign unused_hdr_bits = ^{hdr[47], hdr[44], hdr[35:34]};

endmodule

// File: rtl/db_target_resp.sv
// SRIO target responder: answers doorbell status queries with READY/BUSY,
// unpacks NWRITE payloads to the user write port and drains anything else.
module db_target_resp
    import srio_pkg::*;
#(
    parameter logic [15:0] LOCAL_ID      = 16'h00F0,
    parameter logic [15:0] DB_QUERY_INFO = DB_QUERY_INFO_DEF,
    parameter logic [15:0] DB_READY_INFO = DB_READY_INFO_DEF,
    parameter logic [15:0] DB_BUSY_INFO  = DB_BUSY_INFO_DEF
) (
    input  logic             log_clk,
    input  logic             log_rst,
    db_target_resp_if.slave  bus
);

    state_e      state_q, state_d;
    logic [63:0] resp_data_q, resp_data_d;
    logic [31:0] resp_user_q, resp_user_d;
    logic [15:0] db_cnt_q, db_cnt_d;
    logic [33:0] next_addr_q, next_addr_d;
    logic [5:0]  beat_cnt_q, beat_cnt_d;
    logic [5:0]  exp_beats_q, exp_beats_d;
    logic        wr_en_q, wr_en_d;
    logic [33:0] wr_addr_q, wr_addr_d;
    logic [63:0] wr_data_q, wr_data_d;
    logic [7:0]  wr_keep_q, wr_keep_d;
    logic        wr_last_q, wr_last_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic        treq_ready;
    logic        accept;
    logic        resp_active;
    logic [5:0]  beat_num;
    logic        user_not_ready;

    logic        hdr_is_db;
    logic        hdr_is_nwr;
    logic [7:0]  hdr_tid;
    logic [1:0]  hdr_prio;
    logic [7:0]  hdr_size;
    logic [33:0] hdr_addr;
    logic [15:0] hdr_info;
    logic        unused_req_bits;

    srio_hdr_decode u_hdr_decode (
        .hdr    (bus.treq_tdata_in),
        .is_db  (hdr_is_db),
        .is_nwr (hdr_is_nwr),
        .tid    (hdr_tid),
        .prio   (hdr_prio),
        .size   (hdr_size),
        .addr   (hdr_addr),
        .info   (hdr_info)
    );

    assign unused_req_bits = ^{hdr_size[2:0], bus.treq_tuser_in[15:0]};

    always_comb begin
        unique case (state_q)
            IDLE:     treq_ready = bus.link_initialized;
            DB_RESP:  treq_ready = 1'b0;
            NWR_DATA: treq_ready = bus.user_wr_ready_in;
            default:  treq_ready = 1'b1;
        endcase
    end

    assign accept         = bus.treq_tvalid_in & treq_ready;
    assign beat_num       = beat_cnt_q + 6'd1;
    assign user_not_ready = bus.user_busy_in | ~bus.user_wr_ready_in;

    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned; otherwise synthesis would infer a latch.
    always_comb begin
        state_d     = state_q;
        resp_data_d = resp_data_q;
        resp_user_d = resp_user_q;
        db_cnt_d    = db_cnt_q;
        next_addr_d = next_addr_q;
        beat_cnt_d  = beat_cnt_q;
        exp_beats_d = exp_beats_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        wr_keep_d   = wr_keep_q;
        wr_last_d   = 1'b0;
        done_d      = 1'b0;
        err_d       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (hdr_is_db) begin
                        if (bus.treq_tlast_in) begin
                            db_cnt_d = db_cnt_q + 16'd1;
                            if (hdr_info == DB_QUERY_INFO) begin
                                resp_data_d = db_resp_hdr(hdr_tid, hdr_prio,
                                    user_not_ready ? DB_BUSY_INFO : DB_READY_INFO);
                                resp_user_d = {LOCAL_ID, bus.treq_tuser_in[31:16]};
                                state_d     = DB_RESP;
                            end
                        end else begin
                            err_d   = 1'b1;
                            state_d = DROP;
                        end
                    end else if (hdr_is_nwr) begin
                        if (bus.treq_tlast_in) begin
                            err_d = 1'b1;
                        end else begin
                            next_addr_d = hdr_addr;
                            exp_beats_d = {1'b0, hdr_size[7:3]} + 6'd1;
                            beat_cnt_d  = 6'd0;
                            state_d     = NWR_DATA;
                        end
                    end else if (!bus.treq_tlast_in) begin
                        state_d = DROP;
                    end
                end
            end

            DB_RESP: begin
                if (bus.tresp_tready_in) begin
                    state_d = IDLE;
                end
            end

            NWR_DATA: begin
                if (accept) begin
                    wr_en_d     = 1'b1;
                    wr_addr_d   = next_addr_q;
                    wr_data_d   = bus.treq_tdata_in;
                    wr_keep_d   = bus.treq_tkeep_in;
                    next_addr_d = next_addr_q + 34'd8;
                    beat_cnt_d  = beat_num;
                    if (bus.treq_tlast_in) begin
                        wr_last_d = 1'b1;
                        done_d    = (beat_num == exp_beats_q);
                        err_d     = (beat_num != exp_beats_q);
                        state_d   = IDLE;
                    end else if (beat_num == exp_beats_q) begin
                        // Payload overran the header length: keep the last
                        // legal beat, flag it, and swallow the rest.
                        wr_last_d = 1'b1;
                        err_d     = 1'b1;
                        state_d   = DROP;
                    end
                end
            end

            default: begin
                if (accept && bus.treq_tlast_in) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    // NOTE: state registers take non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge log_clk or posedge log_rst) begin
        if (log_rst) begin
            state_q     <= IDLE;
            resp_data_q <= '0;
            resp_user_q <= '0;
            db_cnt_q    <= '0;
            next_addr_q <= '0;
            beat_cnt_q  <= '0;
            exp_beats_q <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            wr_keep_q   <= '0;
            wr_last_q   <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            resp_data_q <= resp_data_d;
            resp_user_q <= resp_user_d;
            db_cnt_q    <= db_cnt_d;
            next_addr_q <= next_addr_d;
            beat_cnt_q  <= beat_cnt_d;
            exp_beats_q <= exp_beats_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            wr_keep_q   <= wr_keep_d;
            wr_last_q   <= wr_last_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    // Ready is gated by reset so no output is live while reset is held.
    assign bus.treq_tready_o  = treq_ready & ~log_rst;

    assign resp_active        = (state_q == DB_RESP);
    assign bus.tresp_tvalid_o = resp_active;
    assign bus.tresp_tlast_o  = resp_active;
    assign bus.tresp_tkeep_o  = resp_active ? 8'hFF : 8'h00;
    assign bus.tresp_tdata_o  = resp_active ? resp_data_q : 64'h0;
    assign bus.tresp_tuser_o  = resp_active ? resp_user_q : 32'h0;

    assign bus.user_wr_en_o   = wr_en_q;
    assign bus.user_wr_addr_o = wr_addr_q;
    assign bus.user_wr_data_o = wr_data_q;
    assign bus.user_wr_keep_o = wr_keep_q;
    assign bus.user_wr_last_o = wr_last_q;

    assign bus.nwr_done_o     = done_q;
    assign bus.nwr_err_o      = err_q;
    assign bus.db_rx_cnt_o    = db_cnt_q;

endmodule

// File: doc/db_target_resp.md
Name: db_target_resp

Overview:
- Target-side counterpart of the doorbell/NWRITE initiator. Consumes the SRIO target request stream (treq) delivered by the SRIO core.
- For a doorbell "ready query" it returns a doorbell response carrying READY or BUSY on the target response stream (tresp).
- For NWRITE packets it unpacks the header and streams the payload to a user write port.
- Unsupported packets are drained.

Parameters:
- LOCAL_ID, 16'h00F0: this endpoint's device ID; placed in tresp_tuser_o[31:16].
- DB_QUERY_INFO, 16'h0101: doorbell info value that requests a status reply.
- DB_READY_INFO, 16'h0100: info value returned when the target is ready.
- DB_BUSY_INFO, 16'h01FF: info value returned when the target is busy.

Ports:
- log_clk  in  1  clock; all logic on its rising edge.
- log_rst  in  1  reset, asynchronous, active-high.
- link_initialized  in  1  SRIO link up.
- treq_tvalid_in / treq_tready_o / treq_tlast_in  in/out/in  1 each  request AXIS handshake.
- treq_tdata_in  in  64  header or payload beat.
- treq_tkeep_in  in  8  byte enables.
- treq_tuser_in  in  32  {src_id, dest_id}.
- tresp_tvalid_o / tresp_tready_in / tresp_tlast_o  out/in/out  1 each  response AXIS handshake.
- tresp_tdata_o  out  64  doorbell response header.
- tresp_tkeep_o  out  8  always 8'hFF while valid.
- tresp_tuser_o  out  32  {LOCAL_ID, requester src_id}.
- user_busy_in  in  1  user logic cannot accept an NWRITE.
- user_wr_ready_in  in  1  write sink can take a beat.
- user_wr_en_o  out  1  write strobe.
- user_wr_addr_o  out  34  byte address.
- user_wr_data_o  out  64  write data.
- user_wr_keep_o  out  8  byte enables.
- user_wr_last_o  out  1  final beat of the packet.
- nwr_done_o  out  1  one-cycle pulse when an NWRITE completes cleanly.
- nwr_err_o  out  1  one-cycle pulse on a length or protocol error.
- db_rx_cnt_o  out  16  count of received doorbells; wraps at 16'hFFFF to 0.

Behaviour:
- Reset: every output is 0, state is IDLE, counters are 0. Asynchronous reset applied mid-packet aborts immediately; the remainder of that packet arriving after reset is treated as a new header, and the sender is required to reset too.
- Header fields:
  - [63:56] tid, [55:52] ftype, [51:48] ttype, [46:45] prio, [43:36] size (byte count − 1), [33:0] addr.
  - Doorbell info is at [31:16].
  - FTYPE_DB = 4'hA; FTYPE_NWR = 4'h5 with TTYPE_NWR = 4'h4.
- IDLE:
  - treq_tready_o = link_initialized.
  - On header accept, register the header and tuser, then branch:
    - Doorbell with tlast=1: increment db_rx_cnt_o. If info == DB_QUERY_INFO go to DB_RESP, otherwise stay in IDLE (no reply).
    - Doorbell with tlast=0: pulse nwr_err_o, go to DROP.
    - NWRITE with tlast=0: load addr and expected beats = size[7:3] + 1 (1..32), clear the beat count, go to NWR_DATA.
    - NWRITE with tlast=1: no payload; pulse nwr_err_o, stay in IDLE.
    - Any other type: go to DROP, or stay in IDLE if tlast=1.
- DB_RESP:
  - treq_tready_o = 0.
  - tresp_tvalid_o = 1 starting one cycle after header accept. tresp_tlast_o = 1.
  - tresp_tdata_o = {tid, 4'hA, 4'h0, 1'b0, prio_rsp, 1'b0, 12'h0, info, 16'h0}.
  - prio_rsp = prio + 1, saturating at 2'h3.
  - info = DB_BUSY_INFO if (user_busy_in | ~user_wr_ready_in), sampled at header accept; else DB_READY_INFO.
  - Outputs hold stable until tresp_tready_in; then deassert valid and return to IDLE.
- NWR_DATA:
  - treq_tready_o = user_wr_ready_in.
  - A beat accepted in cycle N drives user_wr_* in cycle N+1 with user_wr_en_o = 1, data and keep registered. The sink must absorb that one beat after dropping ready.
  - user_wr_addr_o starts at the header addr and increments by 8 per beat, with 34-bit wrap.
  - user_wr_last_o = 1 on the beat carrying treq_tlast_in.
  - tlast on beat == expected: pulse nwr_done_o together with user_wr_last_o, go to IDLE.
  - tlast on beat < expected: pulse nwr_err_o, go to IDLE.
  - Beat == expected without tlast: pulse nwr_err_o and go to DROP. That beat is still written, with user_wr_last_o = 1.
- DROP: treq_tready_o = 1; discard beats until tlast, then go to IDLE. No writes.
- Ordering: one packet at a time; there is no overlap of request and response.

Decomposition:
- Shared package srio_pkg:
  - FTYPE_DB, FTYPE_NWR, TTYPE_NWR.
  - Header field bit positions.
  - Info codes.
  - State encoding IDLE/DB_RESP/NWR_DATA/DROP (2 bits).
- One natural sub-module, srio_hdr_decode: a combinational field split producing is_db, is_nwr, tid, prio, size, addr, info. It is shared with the initiator's response parser.

Test Plan:
1. Doorbell {tid 8'h00, ftype A, prio 1, info 0101}, tuser 32'h0001_00F0, user idle/ready -> one tresp beat 64'h00A0_4000_0100_0000 (prio 2, info 0100), tuser 32'h00F0_0001, tlast=1; db_rx_cnt_o = 1.
2. Same doorbell with user_busy_in=1, tresp_tready_in held low 5 cycles -> tresp_tdata_o holds info 01FF and tresp_tvalid_o stays 1 for all 5 cycles; treq_tready_o = 0 throughout.
3. NWRITE size 8'h1F (4 beats), addr 34'h100000, data 1..4 -> four writes at 100000/100008/100010/100018; user_wr_last_o on the 4th; nwr_done_o pulses once.
4. Same NWRITE with user_wr_ready_in toggled 1/0 each cycle -> no lost or duplicated beats; treq_tready_o follows the ready signal.
5. NWRITE size 8'h1F with tlast on beat 2 -> 2 writes, nwr_err_o pulse, return to IDLE. Then a size 8'h07 packet with 3 beats -> 1 write, error, DROP swallows 2 beats.
6. Doorbell info 16'h1234 -> no tresp, count increments. Unknown ftype 4'h2 of 3 beats -> drained. Assert log_rst mid-NWRITE -> all outputs 0 asynchronously.
